// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and helpers for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_SLL  = 4'd0;
  localparam logic [3:0] OP_SRA  = 4'd1;
  localparam logic [3:0] OP_SRL  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_NOR  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;
  localparam logic [3:0] OP_SLTU = 4'd12;
  localparam logic [3:0] OP_MULU = 4'd13;
  localparam logic [3:0] OP_DIVU = 4'd14;
  localparam logic [3:0] OP_RSV  = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MULU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Operation request / result bus between register-read and write-back.
interface alu_mc_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [3:0]       alu_op;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result2;
  logic             of;
  logic             cf;
  logic             equal;

  modport master (
    output in_valid, x, y, alu_op,
    input  in_ready, out_valid, result, result2, of, cf, equal
  );

  modport slave (
    input  in_valid, x, y, alu_op,
    output in_ready, out_valid, result, result2, of, cf, equal
  );

endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes,
// with sign correction and divide-exception override applied on the way out.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             last_c,
  output logic [WIDTH-1:0] lo_c,
  output logic [WIDTH-1:0] hi_c,
  output logic             of_c
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] acc_hi, acc_lo, opd, x_raw;
  logic [CW-1:0]    cnt;
  logic             div_q, neg_lo, neg_rem, exc_zero, exc_ovf;

  logic             is_div, sgn, sx, sy;
  logic [WIDTH-1:0] ma, mb;
  logic [WIDTH:0]   sum, shifted, trial;
  logic [2*WIDTH-1:0] prod;

  // Operand decode at accept: magnitudes and result signs.
  always_comb begin
    is_div = (op == OP_DIV) || (op == OP_DIVU);
    sgn    = (op == OP_MUL) || (op == OP_DIV);
    sx     = sgn & x[WIDTH-1];
    sy     = sgn & y[WIDTH-1];
    ma     = sx ? -x : x;
    mb     = sy ? -y : y;
  end

  // One iteration step: MUL adds multiplicand if lsb set, DIV trial-subtracts.
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    trial   = shifted - {1'b0, opd};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi   <= '0;
      acc_lo   <= '0;
      opd      <= '0;
      x_raw    <= '0;
      cnt      <= '0;
      div_q    <= 1'b0;
      neg_lo   <= 1'b0;
      neg_rem  <= 1'b0;
      exc_zero <= 1'b0;
      exc_ovf  <= 1'b0;
    end else if (start) begin
      acc_hi   <= '0;
      acc_lo   <= is_div ? ma : mb;
      opd      <= is_div ? mb : ma;
      x_raw    <= x;
      cnt      <= '0;
      div_q    <= is_div;
      neg_lo   <= sx ^ sy;
      neg_rem  <= sx;
      exc_zero <= is_div && (y == '0);
      exc_ovf  <= is_div && sgn && (x == MIN_VAL) && (y == '1);
    end else if (step) begin
      cnt <= cnt + CW'(1);
      if (div_q) begin
        if (!trial[WIDTH]) begin
          acc_hi <= trial[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi <= shifted[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_hi <= sum[WIDTH:1];
        acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
      end
    end
  end

  assign last_c = step && (cnt == CW'(WIDTH-1));

  // Sign correction and exception override of the finished accumulator.
  always_comb begin
    prod = neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    of_c = exc_zero | exc_ovf;
    if (exc_zero) begin
      lo_c = '1;
      hi_c = x_raw;
    end else if (exc_ovf) begin
      lo_c = MIN_VAL;
      hi_c = '0;
    end else if (div_q) begin
      lo_c = neg_lo  ? -acc_lo : acc_lo;
      hi_c = neg_rem ? -acc_hi : acc_hi;
    end else begin
      lo_c = prod[WIDTH-1:0];
      hi_c = prod[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle simple ops, iterative MUL/DIV, valid/ready handshake.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input logic   clk,
  input logic   rst_n,
  alu_mc_if.slave bus
);

  state_e state, state_nxt;
  logic   accept, start, step, load_simple, load_md;

  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] simple_res;
  logic             simple_of, simple_cf;

  logic             md_last_c, md_of_c;
  logic [WIDTH-1:0] md_lo_c, md_hi_c;

  logic [WIDTH-1:0] result_q, result2_q;
  logic             out_valid_q, of_q, cf_q, equal_q, eq_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Handshake FSM: simple ops complete at accept, MUL/DIV go through ITER and FIX.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    start       = 1'b0;
    load_simple = 1'b0;
    load_md     = 1'b0;
    case (state)
      IDLE: begin
        accept = bus.in_valid;
        if (bus.in_valid) begin
          if (is_muldiv(bus.alu_op)) begin
            start     = 1'b1;
            state_nxt = ITER;
          end else begin
            load_simple = 1'b1;
          end
        end
      end
      ITER: if (md_last_c) state_nxt = FIX;
      FIX: begin
        load_md   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign step = (state == ITER);

  // Single-cycle datapath.
  always_comb begin
    sh         = bus.y[SHW-1:0];
    add_w      = {1'b0, bus.x} + {1'b0, bus.y};
    sub_w      = {1'b0, bus.x} - {1'b0, bus.y};
    simple_res = '0;
    simple_of  = 1'b0;
    simple_cf  = 1'b0;
    case (bus.alu_op)
      OP_SLL:  simple_res = bus.x << sh;
      OP_SRA:  simple_res = WIDTH'($signed(bus.x) >>> sh);
      OP_SRL:  simple_res = bus.x >> sh;
      OP_ADD: begin
        simple_res = add_w[WIDTH-1:0];
        simple_cf  = add_w[WIDTH];
        simple_of  = (bus.x[WIDTH-1] == bus.y[WIDTH-1]) && (add_w[WIDTH-1] != bus.x[WIDTH-1]);
      end
      OP_SUB: begin
        simple_res = sub_w[WIDTH-1:0];
        simple_cf  = sub_w[WIDTH];
        simple_of  = (bus.x[WIDTH-1] != bus.y[WIDTH-1]) && (sub_w[WIDTH-1] != bus.x[WIDTH-1]);
      end
      OP_AND:  simple_res = bus.x & bus.y;
      OP_OR:   simple_res = bus.x | bus.y;
      OP_XOR:  simple_res = bus.x ^ bus.y;
      OP_NOR:  simple_res = ~(bus.x | bus.y);
      OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(bus.x) < $signed(bus.y))};
      OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, (bus.x < bus.y)};
      OP_RSV:  simple_res = add_w[WIDTH-1:0];
      default: simple_res = '0;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .step   (step),
    .op     (bus.alu_op),
    .x      (bus.x),
    .y      (bus.y),
    .last_c (md_last_c),
    .lo_c   (md_lo_c),
    .hi_c   (md_hi_c),
    .of_c   (md_of_c)
  );

  // Result registers hold between out_valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result2_q   <= '0;
      of_q        <= 1'b0;
      cf_q        <= 1'b0;
      equal_q     <= 1'b0;
      eq_pend     <= 1'b0;
    end else begin
      out_valid_q <= load_simple | load_md;
      if (start) eq_pend <= (bus.x == bus.y);
      if (load_simple) begin
        result_q  <= simple_res;
        result2_q <= '0;
        of_q      <= simple_of;
        cf_q      <= simple_cf;
        equal_q   <= (bus.x == bus.y);
      end else if (load_md) begin
        result_q  <= md_lo_c;
        result2_q <= md_hi_c;
        of_q      <= md_of_c;
        cf_q      <= 1'b0;
        equal_q   <= eq_pend;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.result2   = result2_q;
  assign bus.of        = of_q;
  assign bus.cf        = cf_q;
  assign bus.equal     = equal_q;

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Multi-cycle, width-parametrised successor to the single-cycle MIPS ALU.
- Simple ops (shift, add, logic, compare) complete in 1 cycle.
- MUL/DIV are computed iteratively over WIDTH+1 cycles, with signed and unsigned variants.
- Valid/ready handshake so the future multi-cycle datapath can stall on it.
- Sits between the register-file read stage and write-back; result2 feeds HI/LO.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount bits taken from y.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept an operation
- x  in  WIDTH  operand A
- y  in  WIDTH  operand B
- alu_op  in  4  opcode
- out_valid  out  1  one-cycle pulse: result fields updated
- result  out  WIDTH  primary result (LO / quotient)
- result2  out  WIDTH  HI of product / remainder; 0 for other ops
- of  out  1  signed overflow, or divide exception
- cf  out  1  unsigned carry (ADD) / borrow (SUB)
- equal  out  1  x == y for the accepted operation

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, in_ready=1, out_valid=0, result=result2=0, of=cf=equal=0, counter=0.
- Reset asserted mid-iteration aborts the operation; no out_valid is produced for it.
- Opcodes:
  - 0 SLL: x<<y[SHW-1:0]
  - 1 SRA, 2 SRL
  - 3 MUL (signed), 4 DIV (signed)
  - 5 ADD, 6 SUB
  - 7 AND, 8 OR, 9 XOR, 10 NOR
  - 11 SLT, 12 SLTU: result is 1 or 0
  - 13 MULU, 14 DIVU
  - 15 reserved: behaves as ADD with of=cf=0
- Accept occurs when in_valid && in_ready is sampled at edge k. x, y and alu_op are captured there and need not stay stable afterwards.
- in_ready = (state==IDLE); it is combinational from state only.
- Simple ops:
  - result fields registered at edge k; out_valid high for the cycle after edge k.
  - Latency 1, throughput 1/cycle; back-to-back accepts are allowed.
- MUL/DIV:
  - State goes IDLE->ITER at edge k. Signed variants latch operand magnitudes and the result signs.
  - Counter runs 0..WIDTH-1: one shift-add (MUL) or restoring shift-subtract (DIV) per edge, edges k+1..k+WIDTH.
  - ITER->FIX at edge k+WIDTH.
  - FIX applies sign correction and registers outputs at edge k+WIDTH+1, then returns to IDLE. out_valid is high the following cycle.
  - Latency WIDTH+1; in_ready low from after edge k until FIX completes.
- MUL results: result = low WIDTH bits, result2 = high WIDTH bits of the 2*WIDTH product; of=cf=0.
- DIV results: result = quotient truncated toward zero; result2 = remainder, with the sign of x.
- DIV exceptions (detected at accept):
  - y==0: result=all-ones, result2=x, of=1.
  - Signed x==MIN and y==-1: result=MIN, result2=0, of=1.
  - Exception cases still take the full WIDTH+1 latency, so latency is deterministic.
- Flags:
  - ADD/SUB: of = signed overflow; cf = carry-out (ADD) / borrow (SUB, x<y unsigned).
  - All other ops: of=0 and cf=0, except the DIV exceptions.
  - equal evaluated on captured operands for every op.
- Output hold: outputs hold their last values between out_valid pulses. in_valid while in_ready=0 is ignored; the upstream stage must hold it.

Decomposition:
- Package alu_pkg: opcode localparams (OP_SLL..OP_DIVU), state enum (IDLE, ITER, FIX), and function is_muldiv(op).
- One sub-module, alu_muldiv_iter: iteration datapath (accumulator, counter, sign-fix). Parent holds the handshake FSM and the simple-op combinational logic.

Test Plan (WIDTH=32):
- ADD/SUB flags:
  - ADD x=0x7FFFFFFF, y=1 -> next cycle out_valid, result=0x80000000, of=1, cf=0.
  - SUB x=2, y=4 -> result=0xFFFFFFFE, cf=1, of=0.
- Simple-op sweep, x=4, y=2, ops 0..12 except 3,4, issued back-to-back:
  - Results 0x10, 1, 1, 6, 2, 0, 6, 6, 0xFFFFFFF9, 0, 0.
  - One out_valid per cycle; equal=0 throughout.
- Signed MUL x=-3 (0xFFFFFFFD), y=7:
  - in_ready low for 33 cycles.
  - out_valid 33 cycles after accept, result=0xFFFFFFEB, result2=0xFFFFFFFF.
- Signed DIV x=-7, y=2 -> result=0xFFFFFFFD, result2=0xFFFFFFFF.
- DIVU x=0x80000000, y=0x10 -> result=0x08000000, result2=0.
- Exceptions and reset:
  - DIV y=0, x=5 -> result=0xFFFFFFFF, result2=5, of=1, latency 33.
  - DIV x=0x80000000, y=-1 -> result=0x80000000, of=1.
  - Pull rst_n low at iteration 10 of a MUL -> outputs zero immediately, no out_valid, in_ready=1.
